stage_decode: RTL and testbench

Decode/issue stage of the SIMD pipeline: it produces the operands and control that the execute stage consumes. It accepts one 32-bit instruction per cycle and decodes it into `ExecuteOp`, `pcWrEn` and `overwriteFlags`. It reads two vector operands from an internal vector register file, which writeback fills. A scoreboard blocks read-after-write hazards, and a one-deep output register feeds execute.

---
 rtl/simd_pkg.sv | 106 ++++++++++
 rtl/vector_regfile.sv | 35 +++
 rtl/stage_decode.sv | 143 ++++++++++++++
 tb/tb_stage_decode.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared encodings, field positions and decode helpers for the SIMD decode stage
package simd_pkg;

    // Vector geometry
    localparam int VEC_SIZE = 4;
    localparam int REG_SIZE = 8;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int VEC_W    = VEC_SIZE * REG_SIZE;
    localparam int INSTR_W  = 32;

    // Instruction field positions
    localparam int OP_LSB  = 28;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 20;
    localparam int RS2_LSB = 16;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_XOR  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_MUL  = 4'b0100,
        OP_SHR  = 4'b0101,
        OP_SHL  = 4'b0110,
        OP_BZ   = 4'b0111,
        OP_B    = 4'b1000,
        OP_XORI = 4'b1001,
        OP_ADDI = 4'b1010,
        OP_SUBI = 4'b1011,
        OP_MULI = 4'b1100,
        OP_SHRI = 4'b1101,
        OP_SHLI = 4'b1110,
        OP_BN   = 4'b1111
    } opcode_e;

    // ALU operation encodings seen by execute
    localparam logic [2:0] EX_NONE = 3'd0;
    localparam logic [2:0] EX_XOR  = 3'd1;
    localparam logic [2:0] EX_ADD  = 3'd2;
    localparam logic [2:0] EX_SUB  = 3'd3;
    localparam logic [2:0] EX_MUL  = 3'd4;
    localparam logic [2:0] EX_SHR  = 3'd5;
    localparam logic [2:0] EX_SHL  = 3'd6;

    // PC write-enable encodings (one-hot condition select)
    localparam logic [2:0] PC_NONE = 3'b000;
    localparam logic [2:0] PC_JMP  = 3'b100;
    localparam logic [2:0] PC_JZ   = 3'b010;
    localparam logic [2:0] PC_JN   = 3'b001;

    // Control derived purely from the opcode
    typedef struct packed {
        logic [2:0] exec_op;
        logic [2:0] pc_wr_en;
        logic       ovf;
        logic       wr_en;
        logic       use_rs1;
        logic       use_rs2;
        logic       imm_op;
    } dec_ctrl_t;

    // Contents of the output register handed to execute
    typedef struct packed {
        logic             valid;
        logic [2:0]       exec_op;
        logic [2:0]       pc_wr_en;
        logic             ovf;
        logic [VEC_W-1:0] vect1;
        logic [VEC_W-1:0] vect2;
        logic [IDX_W-1:0] rd;
        logic             wr_en;
        logic [IMM_W-1:0] target;
    } stage_out_t;

    // Opcode to control; the ALU op is the low three opcode bits for both R and I forms
    function automatic dec_ctrl_t decode_op(input logic [OP_W-1:0] op);
        dec_ctrl_t c;
        c = '0;
        if (op >= OP_XOR && op <= OP_SHL) begin
            c.exec_op = op[2:0];
            c.ovf     = 1'b1;
            c.wr_en   = 1'b1;
            c.use_rs1 = 1'b1;
            c.use_rs2 = 1'b1;
        end else if (op >= OP_XORI && op <= OP_SHLI) begin
            c.exec_op = op[2:0];
            c.ovf     = 1'b1;
            c.wr_en   = 1'b1;
            c.use_rs1 = 1'b1;
            c.imm_op  = 1'b1;
        end else begin
            case (op)
                OP_B:    c.pc_wr_en = PC_JMP;
                OP_BZ:   c.pc_wr_en = PC_JZ;
                OP_BN:   c.pc_wr_en = PC_JN;
                default: c.pc_wr_en = PC_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/vector_regfile.sv
// rtl/vector_regfile.sv - vector register file with two bypassed read ports and one write port
module vector_regfile
    import simd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [VEC_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr1_i,
    output logic [VEC_W-1:0] rdata1_o,
    input  logic [IDX_W-1:0] raddr2_i,
    output logic [VEC_W-1:0] rdata2_o
);

    logic [VEC_W-1:0] mem_q [NUM_REGS];

    // Storage: cleared by reset, written by writeback on the rising edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first bypass so a consumer released by this writeback sees the new value
    always_comb begin
        rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
        rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
    end

endmodule

// File: rtl/stage_decode.sv
// rtl/stage_decode.sv - decode/issue stage: decoder, RAW scoreboard and output register
module stage_decode
    import simd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instrValid,
    output logic               instrReady,
    input  logic               stallIn,
    input  logic               flush,
    input  logic               wbEn,
    input  logic [IDX_W-1:0]   wbAddr,
    input  logic [VEC_W-1:0]   wbData,
    output logic [2:0]         ExecuteOp,
    output logic [2:0]         pcWrEn,
    output logic               overwriteFlags,
    output logic [VEC_W-1:0]   vect1,
    output logic [VEC_W-1:0]   vect2,
    output logic [IDX_W-1:0]   rdOut,
    output logic               wrEnOut,
    output logic [IMM_W-1:0]   branchTarget,
    output logic               validOut
);

    logic [OP_W-1:0]     op_f;
    logic [IDX_W-1:0]    rd_f;
    logic [IDX_W-1:0]    rs1_f;
    logic [IDX_W-1:0]    rs2_f;
    logic [IMM_W-1:0]    imm_f;
    dec_ctrl_t           ctrl;
    logic [VEC_W-1:0]    rdata1;
    logic [VEC_W-1:0]    rdata2;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                hazard;
    logic                accept;
    stage_out_t          dec_out;
    stage_out_t          out_q;
    stage_out_t          out_d;

    assign op_f  = instr[OP_LSB  +: OP_W];
    assign rd_f  = instr[RD_LSB  +: IDX_W];
    assign rs1_f = instr[RS1_LSB +: IDX_W];
    assign rs2_f = instr[RS2_LSB +: IDX_W];
    assign imm_f = instr[IMM_LSB +: IMM_W];
    assign ctrl  = decode_op(op_f);

    vector_regfile u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (wbEn),
        .waddr_i  (wbAddr),
        .wdata_i  (wbData),
        .raddr1_i (rs1_f),
        .rdata1_o (rdata1),
        .raddr2_i (rs2_f),
        .rdata2_o (rdata2)
    );

    // A source is blocked while busy, unless this cycle's writeback is releasing it
    always_comb begin
        hazard = 1'b0;
        if (ctrl.use_rs1 && busy_q[rs1_f] && !(wbEn && (wbAddr == rs1_f))) begin
            hazard = 1'b1;
        end
        if (ctrl.use_rs2 && busy_q[rs2_f] && !(wbEn && (wbAddr == rs2_f))) begin
            hazard = 1'b1;
        end
    end

    assign instrReady = !stallIn && !hazard && !flush;
    assign accept     = instrValid && instrReady;

    // Build the full execute-side view of the presented instruction; unused fields stay zero
    always_comb begin
        dec_out          = '0;
        dec_out.valid    = 1'b1;
        dec_out.exec_op  = ctrl.exec_op;
        dec_out.pc_wr_en = ctrl.pc_wr_en;
        dec_out.ovf      = ctrl.ovf;
        dec_out.wr_en    = ctrl.wr_en;
        if (ctrl.use_rs1) begin
            dec_out.vect1 = rdata1;
        end
        if (ctrl.use_rs2) begin
            dec_out.vect2 = rdata2;
        end else if (ctrl.imm_op) begin
            dec_out.vect2 = {VEC_SIZE{imm_f[REG_SIZE-1:0]}};
        end
        if (ctrl.wr_en) begin
            dec_out.rd = rd_f;
        end
        if (ctrl.pc_wr_en != PC_NONE) begin
            dec_out.target = imm_f;
        end
    end

    // Output register priority: flush bubble, stall hold, accept, otherwise bubble
    always_comb begin
        out_d = '0;
        if (flush) begin
            out_d = '0;
        end else if (stallIn) begin
            out_d = out_q;
        end else if (accept) begin
            out_d = dec_out;
        end
    end

    // Scoreboard next state: clear on writeback first, so a same-edge set overrides it
    always_comb begin
        busy_d = busy_q;
        if (wbEn) begin
            busy_d[wbAddr] = 1'b0;
        end
        if (accept && ctrl.wr_en) begin
            busy_d[rd_f] = 1'b1;
        end
    end

    // State update for the output register and scoreboard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    assign validOut       = out_q.valid;
    assign ExecuteOp      = out_q.exec_op;
    assign pcWrEn         = out_q.pc_wr_en;
    assign overwriteFlags = out_q.ovf;
    assign vect1          = out_q.vect1;
    assign vect2          = out_q.vect2;
    assign rdOut          = out_q.rd;
    assign wrEnOut        = out_q.wr_en;
    assign branchTarget   = out_q.target;

endmodule

// File: tb/tb_stage_decode.sv
// tb/tb_stage_decode.sv - self-checking bench for stage_decode
module tb_stage_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instrValid;
    logic        instrReady;
    logic        stallIn;
    logic        flush;
    logic        wbEn;
    logic [3:0]  wbAddr;
    logic [31:0] wbData;
    logic [2:0]  ExecuteOp;
    logic [2:0]  pcWrEn;
    logic        overwriteFlags;
    logic [31:0] vect1;
    logic [31:0] vect2;
    logic [3:0]  rdOut;
    logic        wrEnOut;
    logic [15:0] branchTarget;
    logic        validOut;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stage_decode dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .stallIn        (stallIn),
        .flush          (flush),
        .wbEn           (wbEn),
        .wbAddr         (wbAddr),
        .wbData         (wbData),
        .ExecuteOp      (ExecuteOp),
        .pcWrEn         (pcWrEn),
        .overwriteFlags (overwriteFlags),
        .vect1          (vect1),
        .vect2          (vect2),
        .rdOut          (rdOut),
        .wrEnOut        (wrEnOut),
        .branchTarget   (branchTarget),
        .validOut       (validOut)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers, busy flags and the expected output word
    logic [31:0] m_reg  [16];
    bit          m_busy [16];
    logic        e_valid;
    logic [2:0]  e_op;
    logic [2:0]  e_pc;
    logic        e_ovf;
    logic        e_wr;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [3:0]  e_rd;
    logic [15:0] e_bt;
    bit          m_acc;
    logic [3:0]  m_op;

    function automatic bit is_r(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd6);
    endfunction

    function automatic bit is_i(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        return (wbEn && wbAddr == a) ? wbData : m_reg[a];
    endfunction

    function automatic bit m_blocked(input logic [3:0] a);
        return m_busy[a] && !(wbEn && wbAddr == a);
    endfunction

    function automatic bit m_hazard();
        logic [3:0] op;
        op = instr[31:28];
        if (is_r(op)) return m_blocked(instr[23:20]) || m_blocked(instr[19:16]);
        if (is_i(op)) return m_blocked(instr[23:20]);
        return 1'b0;
    endfunction

    task automatic m_bubble();
        e_valid = 0; e_op = 0; e_pc = 0; e_ovf = 0; e_wr = 0;
        e_v1 = 0; e_v2 = 0; e_rd = 0; e_bt = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bubble();
            for (int i = 0; i < 16; i++) begin
                m_reg[i]  = 0;
                m_busy[i] = 0;
            end
        end else begin
            m_op  = instr[31:28];
            m_acc = instrValid && !stallIn && !flush && !m_hazard();
            if (flush) begin
                m_bubble();
            end else if (stallIn) begin
                e_valid = e_valid;
            end else if (m_acc) begin
                m_bubble();
                e_valid = 1;
                if (is_r(m_op) || is_i(m_op)) begin
                    e_op  = m_op[2:0];
                    e_ovf = 1;
                    e_wr  = 1;
                    e_rd  = instr[27:24];
                    e_v1  = m_read(instr[23:20]);
                    e_v2  = is_r(m_op) ? m_read(instr[19:16]) : {4{instr[7:0]}};
                end else if (m_op == 4'd8) begin
                    e_pc = 3'b100; e_bt = instr[15:0];
                end else if (m_op == 4'd7) begin
                    e_pc = 3'b010; e_bt = instr[15:0];
                end else if (m_op == 4'd15) begin
                    e_pc = 3'b001; e_bt = instr[15:0];
                end
            end else begin
                m_bubble();
            end
            if (wbEn) begin
                m_busy[wbAddr] = 0;
                m_reg[wbAddr]  = wbData;
            end
            if (m_acc && (is_r(m_op) || is_i(m_op))) m_busy[instr[27:24]] = 1;
        end
    end

    // Compare process: every falling edge, all outputs against the model
    always @(negedge clk) begin
        chk("validOut",       validOut,       e_valid);
        chk("ExecuteOp",      ExecuteOp,      e_op);
        chk("pcWrEn",         pcWrEn,         e_pc);
        chk("overwriteFlags", overwriteFlags, e_ovf);
        chk("wrEnOut",        wrEnOut,        e_wr);
        chk("vect1",          vect1,          e_v1);
        chk("vect2",          vect2,          e_v2);
        chk("rdOut",          rdOut,          e_rd);
        chk("branchTarget",   branchTarget,   e_bt);
        chk("instrReady",     instrReady,     !stallIn && !flush && !m_hazard());
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] w);
        instr = w; instrValid = 1; step();
    endtask

    initial begin
        rst = 0; instr = 0; instrValid = 0; stallIn = 0; flush = 0;
        wbEn = 0; wbAddr = 0; wbData = 0;
        step(); step();
        chk("rst_valid", validOut, 0);
        chk("rst_op", ExecuteOp, 0);
        rst = 1;

        wbEn = 1; wbAddr = 1; wbData = 32'h33CC_AA55; step();
        wbAddr = 2; wbData = 32'h0FF0_55AA; step();
        wbEn = 0; wbAddr = 0; wbData = 0;

        issue(32'h1312_0000);
        chk("vxor_op", ExecuteOp, 3'b001);
        chk("vxor_v1", vect1, 32'h33CC_AA55);
        chk("vxor_v2", vect2, 32'h0FF0_55AA);
        chk("vxor_flags", overwriteFlags, 1);
        chk("vxor_rd", rdOut, 3);
        chk("vxor_valid", validOut, 1);

        issue(32'hA410_0005);
        chk("vaddi_v2", vect2, 32'h0505_0505);
        chk("vaddi_op", ExecuteOp, 3'b010);

        issue(32'h3512_0000);
        chk("vsub_op", ExecuteOp, 3'b011);
        instr = 32'h4652_0000;
        #1 chk("raw_ready0", instrReady, 0);
        step(); step();
        chk("raw_bubble", validOut, 0);
        wbEn = 1; wbAddr = 5; wbData = 32'h24DC_55AB;
        #1 chk("raw_ready1", instrReady, 1);
        step();
        wbEn = 0; wbAddr = 0; wbData = 0; instrValid = 0;
        chk("raw_v1", vect1, 32'h24DC_55AB);
        chk("raw_v2", vect2, 32'h0FF0_55AA);
        chk("raw_op", ExecuteOp, 3'b100);

        issue(32'h7000_0040);
        chk("bz_pc", pcWrEn, 3'b010);
        chk("bz_target", branchTarget, 16'h0040);
        chk("bz_op", ExecuteOp, 0);
        chk("bz_wr", wrEnOut, 0);
        issue(32'h8000_0100);
        chk("b_pc", pcWrEn, 3'b100);
        issue(32'hF000_0200);
        chk("bn_pc", pcWrEn, 3'b001);
        issue(32'h0000_0000);
        chk("nop_valid", validOut, 1);
        chk("nop_op", ExecuteOp, 0);

        issue(32'h1712_0000);
        stallIn = 1; instr = 32'h2812_0000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", instrReady, 0);
            step();
            chk("stall_rd", rdOut, 7);
            chk("stall_valid", validOut, 1);
        end
        flush = 1; step();
        chk("flush_bubble", validOut, 0);
        flush = 0; stallIn = 0; instr = 32'h1980_0000;
        #1 chk("flush_no_busy", instrReady, 1);
        step();

        instr = 32'h1A90_0000;
        #1 chk("hz_ready0", instrReady, 0);
        step();
        rst = 0;
        #1;
        chk("arst_valid", validOut, 0);
        chk("arst_v1", vect1, 0);
        chk("arst_ready", instrReady, 1);
        step();
        rst = 1;
        issue(32'h1B11_0000);
        chk("post_rst_r1", vect1, 0);
        chk("post_rst_valid", validOut, 1);
        instrValid = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
